// File: rtl/rv32i_alu_issue.sv
// rv32i_alu_issue: decode-side producer for the 32-bit ALU.
// Decodes OP, OP-IMM, LUI and AUIPC, selects operands, emits the ALU op
// code and registers the result toward execute behind a valid/ready
// handshake with flush.
//
// Optional macro RV32I_ALU_ISSUE_SKID_EN adds a second (skid) entry so that
// o_ready is a flop with no combinational path from i_ready. Without it the
// block holds a single entry and o_ready = ~o_valid | i_ready.
//
// Handshake: a transfer happens on a side only in a cycle where that side's
// valid and ready are both high at the rising edge; while o_valid=1 and
// i_ready=0 every output holds stable, and i_flush drops all held entries
// and any input offered in that cycle.

module rv32i_alu_issue #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_op_a,
    output logic [XLEN-1:0] o_op_b,
    output logic [3:0]      o_alu_op,
    output logic [4:0]      o_rd,
    output logic            o_rd_we,
    output logic            o_illegal
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    // One decoded issue entry, as presented on the execute side.
    typedef struct packed {
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b;
        logic [3:0]      alu_op;
        logic [4:0]      rd;
        logic            rd_we;
        logic            illegal;
    } entry_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       f7_zero;
    logic       f7_alt;

    assign opcode  = i_instr[6:0];
    assign funct3  = i_instr[14:12];
    assign funct7  = i_instr[31:25];
    assign f7_zero = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt_ext;

    assign imm_i     = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
    assign imm_u     = {i_instr[31:12], 12'b0};
    assign shamt_ext = {{(XLEN-SHAMT_W){1'b0}}, i_instr[20 +: SHAMT_W]};

    logic [3:0]      base_alu;
    logic            dec_legal;
    logic [3:0]      dec_alu;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    entry_t          dec;

    // funct3 to ALU op for both OP and OP-IMM; funct7 adjusts 000 and 101 later.
    always_comb begin
        base_alu = ALU_ADD;
        case (funct3)
            3'b000:  base_alu = ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    end

    // Instruction decode: legality, operand selection and ALU op.
    always_comb begin
        dec_legal = 1'b0;
        dec_alu   = ALU_ADD;
        dec_a     = '0;
        dec_b     = '0;
        case (opcode)
            OPC_OP: begin
                dec_a   = i_rs1_data;
                dec_b   = i_rs2_data;
                dec_alu = base_alu;
                if (funct3 == 3'b000) begin
                    dec_legal = f7_zero | f7_alt;
                    dec_alu   = f7_alt ? ALU_SUB : ALU_ADD;
                end else if (funct3 == 3'b101) begin
                    dec_legal = f7_zero | f7_alt;
                    dec_alu   = f7_alt ? ALU_SRA : ALU_SRL;
                end else begin
                    dec_legal = f7_zero;
                end
            end
            OPC_IMM: begin
                dec_a   = i_rs1_data;
                dec_b   = imm_i;
                dec_alu = base_alu;
                if (funct3 == 3'b001) begin
                    dec_legal = f7_zero;
                    dec_b     = shamt_ext;
                end else if (funct3 == 3'b101) begin
                    dec_legal = f7_zero | f7_alt;
                    dec_alu   = f7_alt ? ALU_SRA : ALU_SRL;
                    dec_b     = shamt_ext;
                end else begin
                    // Upper immediate bits are data here, never funct7.
                    dec_legal = 1'b1;
                end
            end
            OPC_LUI: begin
                dec_legal = 1'b1;
                dec_a     = '0;
                dec_b     = imm_u;
            end
            OPC_AUIPC: begin
                dec_legal = 1'b1;
                dec_a     = i_pc;
                dec_b     = imm_u;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Illegal entries travel as a neutral ADD 0,0 with no writeback.
    always_comb begin
        dec.op_a    = dec_legal ? dec_a : '0;
        dec.op_b    = dec_legal ? dec_b : '0;
        dec.alu_op  = dec_legal ? dec_alu : ALU_ADD;
        dec.rd      = dec_legal ? i_instr[11:7] : 5'd0;
        dec.rd_we   = dec_legal && (i_instr[11:7] != 5'd0);
        dec.illegal = ~dec_legal;
    end

    entry_t out_q, out_d;
    logic   out_valid_q, out_valid_d;
    logic   accept;

`ifdef RV32I_ALU_ISSUE_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   ready_q, ready_d;
    logic   drain;

    // Two-entry skid: the skid slot fills only when the output is stalled,
    // and refills the output on the next drain so order is preserved.
    always_comb begin
        drain        = out_valid_q & i_ready;
        accept       = i_valid & ready_q & ~i_flush;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (i_flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (drain) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (!out_valid_q) begin
            if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end
        end else if (drain) begin
            if (accept) begin
                out_d = dec;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        ready_d = ~skid_valid_d;
    end

    // Output and skid registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign o_ready = ready_q;
`else
    // Single entry: a drain frees the slot in the same cycle, so a new
    // instruction can reload it for full throughput.
    always_comb begin
        o_ready     = ~out_valid_q | i_ready;
        accept      = i_valid & o_ready & ~i_flush;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (i_flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_d       = dec;
            out_valid_d = 1'b1;
        end else if (i_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end
`endif

    assign o_valid   = out_valid_q;
    assign o_op_a    = out_q.op_a;
    assign o_op_b    = out_q.op_b;
    assign o_alu_op  = out_q.alu_op;
    assign o_rd      = out_q.rd;
    assign o_rd_we   = out_q.rd_we;
    assign o_illegal = out_q.illegal;

endmodule

// File: doc/rv32i_alu_issue.md
Name: rv32i_alu_issue

Overview:
- Decode-side producer for the core's 32-bit ALU.
- Takes a fetched RV32I instruction plus the register-file read data, and decodes the integer-compute subset: OP, OP-IMM, LUI and AUIPC.
- Selects the operands, emits the ALU op code, and registers the result toward execute.
- Uses a valid/ready handshake on both sides, with flush support.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- SHAMT_W, 5, shift-amount width, placed in o_op_b[4:0] for immediate shifts.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_flush  in  1  drop all held entries, synchronous.
- i_valid  in  1  upstream has an instruction.
- o_ready  out  1  block can accept an instruction.
- i_instr  in  32  instruction word.
- i_pc  in  32  instruction address.
- i_rs1_data  in  32  value of x[rs1].
- i_rs2_data  in  32  value of x[rs2].
- o_valid  out  1  execute-side entry valid.
- i_ready  in  1  execute accepts the entry.
- o_op_a  out  32  ALU operand A.
- o_op_b  out  32  ALU operand B.
- o_alu_op  out  4  ALU operation code.
- o_rd  out  5  destination register.
- o_rd_we  out  1  writeback enable.
- o_illegal  out  1  instruction not in the supported subset.

Behaviour:
- ALU op codes: ADD=0, SUB=1, SLT=2, SLTU=3, XOR=4, OR=5, AND=6, SLL=7, SRL=8, SRA=9. Codes 10-15 are never emitted.
- Handshake:
  - Input transfer occurs when i_valid && o_ready.
  - Output transfer occurs when o_valid && i_ready.
  - While o_valid=1 and i_ready=0, all outputs hold stable.
- Latency: one cycle. An instruction accepted in cycle N appears on the outputs in cycle N+1.
- Reset (i_rst_n=0 at the edge):
  - o_valid=0, o_op_a=0, o_op_b=0, o_alu_op=0, o_rd=0, o_rd_we=0, o_illegal=0.
  - Any skid entry is emptied.
  - o_ready=1 from the first cycle after reset deasserts.
  - Reset mid-stall discards the held entry.
- Flush:
  - i_flush=1 clears o_valid and the skid entry at the edge.
  - Any input offered in the same cycle is dropped.
  - Flush has priority over acceptance; reset has priority over flush.
- Decode, by opcode i_instr[6:0]:
  - OP (0110011): op_a=rs1_data, op_b=rs2_data.
    - funct3 000 with funct7 0000000 gives ADD; with funct7 0100000 gives SUB.
    - funct3 010 gives SLT; 011 gives SLTU; 100 gives XOR; 110 gives OR; 111 gives AND.
    - funct3 001 gives SLL; 101 gives SRL (funct7 0000000) or SRA (funct7 0100000).
    - funct7 0100000 with any other funct3, or any other funct7, is illegal.
  - OP-IMM (0010011): op_a=rs1_data, op_b=sign-extended imm[11:0].
    - Mapping is the same as OP, but funct3 000 is always ADD.
    - Shifts (001, 101): op_b={27'b0, instr[24:20]}; funct7 rules as in OP. SLLI with funct7≠0 is illegal.
  - LUI (0110111): op_a=0, op_b={instr[31:12],12'b0}, ADD.
  - AUIPC (0010111): op_a=i_pc, op_b={instr[31:12],12'b0}, ADD.
  - Any other opcode is illegal.
- Illegal entries:
  - Still flow through the handshake with o_illegal=1, o_alu_op=ADD, op_a=op_b=0, o_rd_we=0.
- Writeback enable: o_rd_we = legal && (rd≠0). o_rd = instr[11:7], or 0 when illegal.
- Register writes: the output register loads only on acceptance into an empty output or on a simultaneous drain. Otherwise it holds.

Optional Feature:
- Macro: RV32I_ALU_ISSUE_SKID_EN.
- Defined:
  - A second entry (skid buffer) is added, and o_ready is a flop output with no combinational path from i_ready.
  - o_ready=0 only when both entries are full.
  - When the output drains, the skid entry moves to the output the next cycle.
  - Order is preserved, and there are no bubbles under continuous i_valid with i_ready toggling.
- Undefined:
  - Single entry only; o_ready = ~o_valid | i_ready, combinational.
  - Simultaneous drain and accept reloads the output in the same cycle, giving full throughput when i_ready=1.

Test Plan:
- Reset: hold i_rst_n=0 for 2 cycles with i_valid=1 -> o_valid=0 and all outputs 0. After release o_ready=1.
- SUB: instr 0x40208033 (sub x0,x1,x2), rs1=7, rs2=3 -> next cycle o_alu_op=1, op_a=7, op_b=3, o_rd=0, o_rd_we=0, o_illegal=0.
- SRAI/AUIPC: instr 0x4050D093 (srai x1,x1,5) -> alu_op=9, op_b=5, rd_we=1. instr 0x12345117 (auipc x2), pc=0x100 -> alu_op=0, op_a=0x100, op_b=0x12345000.
- Illegal: instr 0x40209033 (funct7 0100000 with funct3 001) -> o_illegal=1, rd_we=0, alu_op=0. Load opcode 0000011 -> o_illegal=1.
- Backpressure: stream 4 instructions with i_valid=1 and i_ready=0 for 3 cycles, then 1 -> outputs stable while stalled, all 4 delivered in order, none lost or duplicated. With the skid macro defined, o_ready drops only after 2 accepts.
- Flush: o_valid=1 and stalled, then i_flush=1 in the same cycle as a new i_valid -> next cycle o_valid=0 and the new instruction is not delivered.
